fft_frame_loader: RTL and testbench

Front-end feeder for the 64-point fft core. Accepts complex samples one per handshake on a serial valid/ready stream and assembles them into the parallel Re/Im frame arrays the fft core consumes. Issues the one-cycle start pulse to the core, then blocks further input until the core signals completion. The core's input router does the bit-reversal, so samples are stored in natural order.

---
 rtl/fft_frame_loader.sv | 136 +++++++++++++
 tb/tb_fft_frame_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//   Front-end feeder for the fft core. Collects complex samples arriving one per
//   valid/ready handshake into natural-order Re/Im frame arrays, pulses start
//   for one cycle once a full frame is held, then stalls input until the core
//   reports fft_done. All state moves on the falling clock edge, as the core does.
//
// Ports
//   clk        clock (falling edge active)
//   rst        asynchronous active-low reset
//   in_valid   upstream sample valid
//   in_ready   loader accepts a sample this cycle (registered)
//   in_re      sample real part
//   in_im      sample imaginary part
//   in_last    final sample of a frame, qualified by in_valid
//   fft_done   one-cycle pulse from the core: frame processed
//   start      one-cycle pulse to the core start input
//   frame_re   real frame, entry k at [k*S_WIDTH +: S_WIDTH], k = arrival order
//   frame_im   imaginary frame, same layout
//   frame_err  one-cycle pulse: frame aborted, in_last arrived before the last slot
//   fill_level samples held in the frame being filled (0..D_WIDTH)
module fft_frame_loader #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int S_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [S_WIDTH-1:0]           in_re,
  input  logic [S_WIDTH-1:0]           in_im,
  input  logic                         in_last,
  input  logic                         fft_done,
  output logic                         start,
  output logic [S_WIDTH*D_WIDTH-1:0]   frame_re,
  output logic [S_WIDTH*D_WIDTH-1:0]   frame_im,
  output logic                         frame_err,
  output logic [LOG_2_WIDTH:0]         fill_level
);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    FIRE      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [LOG_2_WIDTH-1:0] IDX_LAST   = LOG_2_WIDTH'(D_WIDTH - 1);
  localparam logic [LOG_2_WIDTH:0]   FILL_FULL  = (LOG_2_WIDTH + 1)'(D_WIDTH);

  state_t                 state;
  logic [LOG_2_WIDTH-1:0] idx;

  logic accept;
  logic at_last;
  logic short_frame;
  logic store;

  // in_ready is only ever high in FILL, but gating with the state keeps the
  // accept path obviously confined to the fill phase.
  assign accept      = in_valid & in_ready & (state == FILL);
  assign at_last     = (idx == IDX_LAST);
  // A premature in_last throws away the whole partial frame, including the
  // sample carrying it. A missing in_last at the final slot is tolerated.
  assign short_frame = accept & in_last & ~at_last;
  assign store       = accept & ~short_frame;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      idx        <= '0;
      fill_level <= '0;
      in_ready   <= 1'b0;
      start      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      start     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (at_last) begin
              // idx stays at the last slot; it is cleared when the core releases us.
              state      <= FIRE;
              start      <= 1'b1;
              in_ready   <= 1'b0;
              fill_level <= FILL_FULL;
            end else if (in_last) begin
              idx        <= '0;
              fill_level <= '0;
              frame_err  <= 1'b1;
            end else begin
              idx        <= idx + 1'b1;
              fill_level <= fill_level + 1'b1;
            end
          end
        end
        FIRE: begin
          in_ready <= 1'b0;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          in_ready <= 1'b0;
          if (fft_done) begin
            idx        <= '0;
            fill_level <= '0;
            in_ready   <= 1'b1;
            state      <= FILL;
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= FILL;
        end
      endcase
    end
  end

  // Frame storage: one write-enable per entry decoded from idx. Entries are
  // only written during FILL, so the arrays are frozen from the accept of the
  // last sample until fft_done.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      frame_re <= '0;
      frame_im <= '0;
    end else begin
      for (int k = 0; k < D_WIDTH; k++) begin
        if (store && (idx == LOG_2_WIDTH'(k))) begin
          frame_re[k*S_WIDTH +: S_WIDTH] <= in_re;
          frame_im[k*S_WIDTH +: S_WIDTH] <= in_im;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
module tb_fft_frame_loader;

  localparam int D  = 64;
  localparam int LW = 6;
  localparam int SW = 16;

  logic              clk = 1'b1;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SW-1:0]     in_re = '0;
  logic [SW-1:0]     in_im = '0;
  logic              in_last = 1'b0;
  logic              fft_done = 1'b0;
  logic              start;
  logic [SW*D-1:0]   frame_re;
  logic [SW*D-1:0]   frame_im;
  logic              frame_err;
  logic [LW:0]       fill_level;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: expected frame contents, number of samples held,
  // and the expected values of the pulse/handshake outputs after each edge.
  logic [SW-1:0] m_re [D];
  logic [SW-1:0] m_im [D];
  int            m_cnt;
  bit            m_ready;
  bit            m_start;
  bit            m_err;

  fft_frame_loader #(.D_WIDTH(D), .LOG_2_WIDTH(LW), .S_WIDTH(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_last    (in_last),
    .fft_done   (fft_done),
    .start      (start),
    .frame_re   (frame_re),
    .frame_im   (frame_im),
    .frame_err  (frame_err),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] get_re(int k);
    return frame_re[k*SW +: SW];
  endfunction

  function automatic logic [SW-1:0] get_im(int k);
    return frame_im[k*SW +: SW];
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ready = 0; m_start = 0; m_err = 0;
    for (int k = 0; k < D; k++) begin
      m_re[k] = '0; m_im[k] = '0;
    end
  endtask

  // Drive one cycle of inputs, let the falling edge happen, advance the model.
  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input bit v, input logic [SW-1:0] re, input logic [SW-1:0] im,
                      input bit last, input bit done);
    bit was_ready, was_start;
    in_valid = v; in_re = re; in_im = im; in_last = last; fft_done = done;
    was_ready = m_ready; was_start = m_start;
    m_start = 0; m_err = 0;
    if (was_ready) begin
      if (v) begin
        if (m_cnt == D-1) begin
          m_re[m_cnt] = re; m_im[m_cnt] = im; m_cnt = D; m_ready = 0; m_start = 1;
        end else if (last) begin
          m_cnt = 0; m_err = 1;
        end else begin
          m_re[m_cnt] = re; m_im[m_cnt] = im; m_cnt++;
        end
      end
    end else if (m_cnt == D) begin
      // Frame handed off; the cycle with start high ignores fft_done.
      if (!was_start && done) begin
        m_cnt = 0; m_ready = 1;
      end
    end else begin
      m_ready = 1;  // first edge after reset release
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = 1; in_re = 16'h1234; in_im = 16'h5678;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, start, frame_err, fill_level} !== 10'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want %b", {in_ready, start, frame_err, fill_level}, 10'b0);
    end
    n_cmp++;
    if ((frame_re !== '0) || (frame_im !== '0)) begin
      n_bad++; $display("FAIL reset_arrays got re0=%h im0=%h want 0", get_re(0), get_im(0));
    end
    rst = 1'b1;
    model_reset();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_release_ready got %b want 0", in_ready);
    end
    step(1, 16'h1234, 16'h5678, 0, 0);
    n_cmp++;
    if ({in_ready, start, frame_err, fill_level} !== {m_ready, m_start, m_err, 7'(m_cnt)}) begin
      n_bad++; $display("FAIL reset_first_edge got %b want %b", {in_ready, start, frame_err, fill_level}, {m_ready, m_start, m_err, 7'(m_cnt)});
    end
  endtask

  task automatic test_full_frame();
    int starts = 0;
    for (int k = 0; k < D; k++) begin
      step(1, SW'(k), 16'hFFFF - SW'(k), k == D-1, 0);
      starts += int'(start);
      n_cmp++;
      if ({in_ready, start, frame_err, fill_level} !== {m_ready, m_start, m_err, 7'(m_cnt)}) begin
        n_bad++; $display("FAIL full_ctrl k=%0d got %b want %b", k, {in_ready, start, frame_err, fill_level}, {m_ready, m_start, m_err, 7'(m_cnt)});
      end
    end
    for (int k = 0; k < D; k++) begin
      n_cmp++;
      if ({get_re(k), get_im(k)} !== {SW'(k), 16'hFFFF - SW'(k)}) begin
        n_bad++; $display("FAIL full_entry k=%0d got %h/%h want %h/%h", k, get_re(k), get_im(k), SW'(k), 16'hFFFF - SW'(k));
      end
    end
    step(0, 0, 0, 0, 0);
    starts += int'(start);
    n_cmp++;
    if ({in_ready, start, fill_level, starts} !== {1'b0, 1'b0, 7'd64, 32'd1}) begin
      n_bad++; $display("FAIL full_after got rdy=%b start=%b fill=%0d starts=%0d want 0 0 64 1", in_ready, start, fill_level, starts);
    end
  endtask

  task automatic test_blocking();
    logic [SW-1:0] a, b;
    for (int c = 0; c < 20; c++) begin
      step(1, SW'($urandom), SW'($urandom), c[0], 0);
      n_cmp++;
      if ({in_ready, start, frame_err, fill_level} !== {m_ready, m_start, m_err, 7'(m_cnt)}) begin
        n_bad++; $display("FAIL block_ctrl c=%0d got %b want %b", c, {in_ready, start, frame_err, fill_level}, {m_ready, m_start, m_err, 7'(m_cnt)});
      end
    end
    for (int k = 0; k < D; k++) begin
      n_cmp++;
      if ({get_re(k), get_im(k)} !== {m_re[k], m_im[k]}) begin
        n_bad++; $display("FAIL block_hold k=%0d got %h/%h want %h/%h", k, get_re(k), get_im(k), m_re[k], m_im[k]);
      end
    end
    step(0, 0, 0, 0, 1);
    n_cmp++;
    if ({in_ready, fill_level} !== {1'b1, 7'd0}) begin
      n_bad++; $display("FAIL block_release got rdy=%b fill=%0d want 1 0", in_ready, fill_level);
    end
    a = SW'($urandom); b = SW'($urandom);
    step(1, a, b, 0, 0);
    n_cmp++;
    if ({get_re(0), get_im(0), fill_level} !== {a, b, 7'd1}) begin
      n_bad++; $display("FAIL block_next_idx0 got %h/%h fill=%0d want %h/%h 1", get_re(0), get_im(0), fill_level, a, b);
    end
  endtask

  task automatic test_short_frame();
    logic [SW-1:0] old9_re;
    while (m_cnt < 9) step(1, SW'($urandom), SW'($urandom), 0, 0);
    old9_re = m_re[9];
    step(1, SW'($urandom), SW'($urandom), 1, 0);
    n_cmp++;
    if ({frame_err, start, in_ready, fill_level} !== {1'b1, 1'b0, 1'b1, 7'd0}) begin
      n_bad++; $display("FAIL short_err got err=%b start=%b rdy=%b fill=%0d want 1 0 1 0", frame_err, start, in_ready, fill_level);
    end
    n_cmp++;
    if (get_re(9) !== old9_re) begin
      n_bad++; $display("FAIL short_discard got %h want %h", get_re(9), old9_re);
    end
    step(0, 0, 0, 0, 0);
    n_cmp++;
    if ({frame_err, start} !== 2'b00) begin
      n_bad++; $display("FAIL short_pulse got err=%b start=%b want 0 0", frame_err, start);
    end
    for (int k = 0; k < D; k++) begin
      step(1, SW'($urandom), SW'($urandom), k == D-1, 0);
      n_cmp++;
      if ({in_ready, start, frame_err, fill_level} !== {m_ready, m_start, m_err, 7'(m_cnt)}) begin
        n_bad++; $display("FAIL short_refill k=%0d got %b want %b", k, {in_ready, start, frame_err, fill_level}, {m_ready, m_start, m_err, 7'(m_cnt)});
      end
    end
    for (int k = 0; k < D; k++) begin
      n_cmp++;
      if ({get_re(k), get_im(k)} !== {m_re[k], m_im[k]}) begin
        n_bad++; $display("FAIL short_refill_entry k=%0d got %h/%h want %h/%h", k, get_re(k), get_im(k), m_re[k], m_im[k]);
      end
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_bursty();
    logic [SW-1:0] re, im;
    bit v, last, acc;
    int cyc = 0, starts = 0, fired = 0;
    re = SW'($urandom); im = SW'($urandom);
    while (!fired && cyc < 2000) begin
      v = (cyc % 2 == 0) ? 1'b1 : 1'($urandom);
      // in_last is optional on the final sample; omit it at random.
      last = (m_cnt == D-1) ? 1'($urandom) : 1'b0;
      acc = v && m_ready;
      step(v, re, im, last, 0);
      starts += int'(start);
      fired = m_start;
      if (acc) begin re = SW'($urandom); im = SW'($urandom); end
      n_cmp++;
      if ({in_ready, start, frame_err, fill_level} !== {m_ready, m_start, m_err, 7'(m_cnt)}) begin
        n_bad++; $display("FAIL burst_ctrl cyc=%0d got %b want %b", cyc, {in_ready, start, frame_err, fill_level}, {m_ready, m_start, m_err, 7'(m_cnt)});
      end
      cyc++;
    end
    if (!fired) begin
      n_cmp++; n_bad++; $display("FAIL burst_timeout got no start after %0d cycles want start", cyc);
    end
    for (int c = 0; c < 5; c++) begin
      step(1, SW'($urandom), SW'($urandom), 0, 0);
      starts += int'(start);
    end
    for (int k = 0; k < D; k++) begin
      n_cmp++;
      if ({get_re(k), get_im(k)} !== {m_re[k], m_im[k]}) begin
        n_bad++; $display("FAIL burst_entry k=%0d got %h/%h want %h/%h", k, get_re(k), get_im(k), m_re[k], m_im[k]);
      end
    end
    n_cmp++;
    if (starts !== 1) begin
      n_bad++; $display("FAIL burst_starts got %0d want 1", starts);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_mid_reset();
    logic [SW-1:0] a, b;
    for (int k = 0; k < D; k++) step(1, SW'($urandom), SW'($urandom), k == D-1, 0);
    n_cmp++;
    if (start !== 1'b1) begin
      n_bad++; $display("FAIL midrst_fire got start=%b want 1", start);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({start, in_ready, fill_level} !== {1'b0, 1'b0, 7'd0}) begin
      n_bad++; $display("FAIL midrst_async got start=%b rdy=%b fill=%0d want 0 0 0", start, in_ready, fill_level);
    end
    n_cmp++;
    if ((frame_re !== '0) || (frame_im !== '0)) begin
      n_bad++; $display("FAIL midrst_arrays got re0=%h im0=%h want 0", get_re(0), get_im(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 1);
      n_cmp++;
      if ({in_ready, start, frame_err, fill_level} !== {m_ready, m_start, m_err, 7'(m_cnt)}) begin
        n_bad++; $display("FAIL midrst_spurious_done c=%0d got %b want %b", c, {in_ready, start, frame_err, fill_level}, {m_ready, m_start, m_err, 7'(m_cnt)});
      end
    end
    a = SW'($urandom); b = SW'($urandom);
    step(1, a, b, 0, 0);
    n_cmp++;
    if ({get_re(0), get_im(0), fill_level} !== {a, b, 7'd1}) begin
      n_bad++; $display("FAIL midrst_idx0 got %h/%h fill=%0d want %h/%h 1", get_re(0), get_im(0), fill_level, a, b);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_frame();
    test_blocking();
    test_short_frame();
    test_bursty();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
